// File: rtl/alu_pkg.sv
// Shared types and defaults for the multi-cycle ALU datapath.
package alu_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int OPW_DEF   = 8;
  localparam int ITER      = 8;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_MUL  = 4'b0010,
    OP_DIV  = 4'b0011,
    OP_HALT = 4'b1111
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2,
    S_HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/seq_muldiv.sv
// Iterative engine: shift-add multiply or restoring divide, one bit per cycle.
// Outputs carry the value after the current step so the final step can be registered by the caller.
module seq_muldiv
  import alu_pkg::*;
#(
  parameter int OPW = OPW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic [OPW-1:0]     a,
  input  logic [OPW-1:0]     b,
  output logic               valid,
  output logic [2*OPW-1:0]   product,
  output logic [OPW-1:0]     quotient,
  output logic [OPW-1:0]     remainder
);

  localparam int CW = $clog2(ITER);

  logic             running;
  logic             mode_q;
  logic [CW-1:0]    count;
  logic [2*OPW-1:0] acc;
  logic [2*OPW-1:0] mcand;
  logic [OPW-1:0]   mplier;
  logic [OPW-1:0]   rem;
  logic [OPW-1:0]   quo;
  logic [OPW-1:0]   divisor;

  logic [OPW:0]     trial;
  logic             fits;
  logic [2*OPW-1:0] acc_n;
  logic [OPW-1:0]   rem_n;
  logic [OPW-1:0]   quo_n;

  always_comb begin
    acc_n = acc + (mplier[0] ? mcand : '0);
    trial = {rem, quo[OPW-1]};
    fits  = trial >= {1'b0, divisor};
    rem_n = fits ? OPW'(trial - {1'b0, divisor}) : trial[OPW-1:0];
    quo_n = {quo[OPW-2:0], fits};
  end

  assign valid     = running && (count == CW'(ITER - 1));
  assign product   = acc_n;
  assign quotient  = quo_n;
  assign remainder = rem_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
      mode_q  <= 1'b0;
      count   <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
    end else if (start) begin
      running <= 1'b1;
      mode_q  <= mode;
      count   <= '0;
      acc     <= '0;
      mcand   <= {{OPW{1'b0}}, a};
      mplier  <= b;
      rem     <= '0;
      quo     <= a;
      divisor <= b;
    end else if (running) begin
      count <= count + CW'(1);
      if (valid) running <= 1'b0;
      // Only the selected datapath moves; the other holds its last value.
      if (mode_q) begin
        rem <= rem_n;
        quo <= quo_n;
      end else begin
        acc    <= acc_n;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
    end
  end

endmodule

// File: rtl/alu_datapath.sv
// Multi-cycle ALU: enable/done handshake FSM, flags and result register around seq_muldiv.
// Handshake: enable is sampled in IDLE; done pulses once; HOLD waits for enable low before re-arming.
module alu_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPW   = OPW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [3:0]       opcode,
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero,
  output logic             bad_op,
  output state_t           fsm_state
);

  state_t           state;
  state_t           state_n;
  logic [3:0]       op_q;
  logic [OPW-1:0]   a_q;
  logic [OPW-1:0]   b_q;
  logic             accept;
  logic             iter_op;
  logic             start;
  logic             complete;
  logic             eng_valid;
  logic [2*OPW-1:0] product;
  logic [OPW-1:0]   quotient;
  logic [OPW-1:0]   remainder;

  assign accept   = (state == S_IDLE) && enable;
  assign iter_op  = (op_q == OP_MUL) || (op_q == OP_DIV);
  assign start    = accept && ((opcode == OP_MUL) || (opcode == OP_DIV));
  assign complete = (state == S_EXEC) && (!iter_op || eng_valid);

  seq_muldiv #(.OPW(OPW)) u_engine (
    .clk       (clk),
    .rst       (reset),
    .start     (start),
    .mode      (opcode == OP_DIV),
    .a         (a),
    .b         (b),
    .valid     (eng_valid),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (enable) state_n = S_EXEC;
      S_EXEC: if (complete) state_n = S_DONE;
      S_DONE: state_n = S_HOLD;
      S_HOLD: if (!enable) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign done      = (state == S_DONE);
  assign busy      = (state == S_EXEC) || (state == S_DONE);
  assign fsm_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
      bad_op      <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_q <= opcode;
        a_q  <= a;
        b_q  <= b;
      end
      // Flags change only here, so they describe the last completed operation.
      if (complete) begin
        div_by_zero <= 1'b0;
        bad_op      <= 1'b0;
        case (op_q)
          OP_ADD: result <= WIDTH'(a_q) + WIDTH'(b_q);
          OP_SUB: result <= WIDTH'(a_q) - WIDTH'(b_q);
          OP_MUL: result <= WIDTH'(product);
          OP_DIV: begin
            if (b_q == '0) begin
              result      <= '1;
              div_by_zero <= 1'b1;
            end else begin
              result <= WIDTH'({remainder, quotient});
            end
          end
          default: bad_op <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_datapath.sv
// Directed bench for alu_datapath: hand-computed vectors checked with immediate assertions.
module tb_alu_datapath;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  opcode;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        done;
  logic        busy;
  logic [15:0] result;
  logic        div_by_zero;
  logic        bad_op;
  state_t      fsm_state;

  int vectors     = 0;
  int miscompares = 0;
  int pulses;

  always #5 clk = ~clk;

  alu_datapath #(.WIDTH(16), .OPW(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .opcode      (opcode),
    .a           (a),
    .b           (b),
    .done        (done),
    .busy        (busy),
    .result      (result),
    .div_by_zero (div_by_zero),
    .bad_op      (bad_op),
    .fsm_state   (fsm_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request; returns just after the accepting edge E0 with inputs scrambled.
  task automatic start_op(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
    enable = 1'b1;
    opcode = op;
    a      = x;
    b      = y;
    step();
    opcode = ~op;
    a      = ~x;
    b      = ~y;
  endtask

  // Seven iteration edges with done counted, then the completing edge E0+8.
  task automatic run_iter(output int early);
    early = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      early += int'(done);
    end
    step();
  endtask

  task automatic release_op();
    enable = 1'b0;
    step();
    step();
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    opcode = 4'd0;
    a      = 8'd0;
    b      = 8'd0;
    step();
    step();
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_state", 32'(fsm_state), 32'(S_IDLE));
    reset = 1'b0;
    step();
    chk("idle_no_start", 32'(busy), 32'h0);

    // ADD 200+100
    start_op(OP_ADD, 8'd200, 8'd100);
    chk("add_busy_e0", 32'(busy), 32'h1);
    chk("add_done_e0", 32'(done), 32'h0);
    step();
    chk("add_result", 32'(result), 32'h012C);
    chk("add_done", 32'(done), 32'h1);
    chk("add_bad_op", 32'(bad_op), 32'h0);
    step();
    chk("add_done_off", 32'(done), 32'h0);
    chk("add_hold", 32'(fsm_state), 32'(S_HOLD));
    release_op();
    chk("add_idle", 32'(fsm_state), 32'(S_IDLE));

    // SUB 3-5 wraps
    start_op(OP_SUB, 8'd3, 8'd5);
    step();
    chk("sub_result", 32'(result), 32'hFFFE);
    chk("sub_done", 32'(done), 32'h1);
    release_op();

    // MUL 255*255, enable dropped mid-flight
    start_op(OP_MUL, 8'd255, 8'd255);
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      if (i == 2) enable = 1'b0;
      step();
      pulses += int'(done);
      chk("mul_busy_exec", 32'(busy), 32'h1);
    end
    chk("mul_early_done", 32'(pulses), 32'h0);
    step();
    chk("mul_result", 32'(result), 32'hFE01);
    chk("mul_done", 32'(done), 32'h1);
    chk("mul_busy_done", 32'(busy), 32'h1);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      pulses += int'(done);
    end
    chk("mul_single_done", 32'(pulses), 32'h0);
    chk("mul_back_idle", 32'(fsm_state), 32'(S_IDLE));

    // DIV 200/7 = 28 r 4
    start_op(OP_DIV, 8'd200, 8'd7);
    run_iter(pulses);
    chk("div_early_done", 32'(pulses), 32'h0);
    chk("div_result", 32'(result), 32'h041C);
    chk("div_done", 32'(done), 32'h1);
    chk("div_dbz", 32'(div_by_zero), 32'h0);
    release_op();

    // DIV by zero
    start_op(OP_DIV, 8'd9, 8'd0);
    run_iter(pulses);
    chk("dz_early_done", 32'(pulses), 32'h0);
    chk("dz_result", 32'(result), 32'hFFFF);
    chk("dz_flag", 32'(div_by_zero), 32'h1);
    release_op();

    // ADD clears div_by_zero only on completion
    start_op(OP_ADD, 8'd1, 8'd2);
    chk("dz_held_in_exec", 32'(div_by_zero), 32'h1);
    step();
    chk("add2_result", 32'(result), 32'h0003);
    chk("dz_cleared", 32'(div_by_zero), 32'h0);
    release_op();

    // MUL 20*233 = 0x1234, then an illegal opcode
    start_op(OP_MUL, 8'd20, 8'd233);
    run_iter(pulses);
    chk("mul2_result", 32'(result), 32'h1234);
    release_op();
    start_op(4'b0101, 8'd7, 8'd9);
    step();
    chk("bad_result_kept", 32'(result), 32'h1234);
    chk("bad_flag", 32'(bad_op), 32'h1);
    chk("bad_done", 32'(done), 32'h1);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      pulses += int'(done);
    end
    chk("hold_no_redone", 32'(pulses), 32'h0);
    chk("hold_state", 32'(fsm_state), 32'(S_HOLD));
    release_op();

    // Reset during MUL after four iterations
    start_op(OP_MUL, 8'd255, 8'd255);
    for (int i = 0; i < 4; i++) step();
    #2;
    reset  = 1'b1;
    enable = 1'b0;
    #1;
    chk("arst_result", 32'(result), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_done", 32'(done), 32'h0);
    chk("arst_bad_op", 32'(bad_op), 32'h0);
    chk("arst_dbz", 32'(div_by_zero), 32'h0);
    step();
    step();
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      pulses += int'(done) + int'(busy);
    end
    chk("arst_no_done", 32'(pulses), 32'h0);
    chk("arst_idle", 32'(fsm_state), 32'(S_IDLE));

    // Recovery: ADD 255+255
    start_op(OP_ADD, 8'd255, 8'd255);
    step();
    chk("add3_result", 32'(result), 32'h01FE);
    chk("add3_done", 32'(done), 32'h1);
    release_op();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_datapath.md
ALU_DATAPATH -- requirements
Module: alu_datapath

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning result width.
REQ-002 SHALL have parameter OPW, default 8, meaning operand width.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1, meaning start request from the controller, held high until done is seen.
REQ-006 SHALL have port opcode, input, 4, meaning operation select, sampled with enable.
REQ-007 SHALL have ports a and b, input, OPW each, meaning unsigned operands.
REQ-008 SHALL have port done, output, 1, meaning a one-cycle completion pulse.
REQ-009 SHALL have port busy, output, 1, meaning an operation is in progress (states EXEC and DONE).
REQ-010 SHALL have port result, output, WIDTH, meaning the registered result of the last completed operation.
REQ-011 SHALL have port div_by_zero, output, 1, meaning the last DIV had b == 0.
REQ-012 SHALL have port bad_op, output, 1, meaning the last accepted opcode was not 0000-0011.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, DONE and HOLD.
REQ-014 IDLE SHALL, on an edge with enable=1 (edge E0), latch opcode, a and b, clear the iteration counter and go to EXEC.
REQ-015 ADD (0000) SHALL set result = zero-extended a+b at edge E0+1 and go to DONE.
REQ-016 SUB (0001) SHALL set result = (a-b) mod 2^WIDTH at edge E0+1 and go to DONE.
REQ-017 MUL (0010) SHALL run a shift-add, one operand bit per cycle; 8 iterations at edges E0+1..E0+8; result = a*b, registered at E0+8; then go to DONE.
REQ-018 DIV (0011) SHALL run restoring division, 8 iterations at edges E0+1..E0+8; result = {remainder[7:0], quotient[7:0]}; then go to DONE.
REQ-019 DIV with b==0 SHALL still take 8 iterations and SHALL set result=16'hFFFF and div_by_zero=1.
REQ-020 Any other opcode SHALL leave result unchanged, set bad_op=1 at E0+1 and go to DONE.
REQ-021 div_by_zero and bad_op SHALL be updated only when an operation completes, and cleared when the next operation completes without the condition.
REQ-022 DONE SHALL assert done for exactly one cycle, then go to HOLD.
REQ-023 HOLD SHALL wait for enable=0 and then return to IDLE; done SHALL NOT reassert while enable stays high.
REQ-024 Changes on opcode, a or b after E0 SHALL NOT affect the operation in flight.
REQ-025 enable falling during EXEC SHALL NOT abort the operation; completion SHALL still pulse done.
REQ-026 result SHALL be stable from the done pulse until the next completion.

Reset
REQ-027 reset SHALL asynchronously force state IDLE, counter 0, result 0, done 0, busy 0, div_by_zero 0 and bad_op 0.
REQ-028 reset during EXEC SHALL discard the partial operation; no done pulse SHALL follow release.
REQ-029 After reset release, a new operation SHALL start only on a sampled enable=1 in IDLE.

Structure
REQ-030 Package alu_pkg SHALL hold the opcode enum (OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_HALT=4'b1111), the FSM state enum, WIDTH/OPW defaults and ITER=8.
REQ-031 The iterative multiply/divide engine SHALL be a sub-module named seq_muldiv (start, mode, a, b -> valid, product/quotient/remainder).
REQ-032 alu_datapath SHALL own the FSM, the handshake, the flags and the result register.

Verification
REQ-033 ADD a=200, b=100 -> result=16'h012C, done pulse in the cycle after E0+1, bad_op=0.
REQ-034 SUB a=3, b=5 -> result=16'hFFFE in the cycle after E0+1.
REQ-035 MUL a=255, b=255 -> result=16'hFE01, done exactly once, after E0+8; busy high through DONE.
REQ-036 DIV a=200, b=7 -> result=16'h041C; then DIV a=9, b=0 -> result=16'hFFFF, div_by_zero=1; the next ADD clears div_by_zero.
REQ-037 MUL start, reset asserted at iteration 4 -> all outputs 0 immediately, no done after release; enable held high 10 cycles after a done -> no second done.
REQ-038 opcode=4'b0101 with result previously 16'h1234 -> result stays 16'h1234, bad_op=1, one done pulse.
